// File: rtl/mac_ctrl_pkg.sv
// Shared constants for the two-channel dot-product MAC arbiter.
// This package holds the FSM state codes, the channel count and the operand/product widths.
package mac_ctrl_pkg;

    localparam int unsigned N_CHAN        = 2;
    localparam int unsigned ACC_W_DEFAULT = 12;
    localparam int unsigned OPND_W        = 4;
    localparam int unsigned PROD_W        = 2 * OPND_W;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_BUSY   = 2'd1;
    localparam logic [1:0] ST_RESULT = 2'd2;

    // Unsigned 4x4 product, full 8-bit result
    function automatic logic [PROD_W-1:0] mul4(input logic [OPND_W-1:0] a,
                                               input logic [OPND_W-1:0] b);
        return PROD_W'(a) * PROD_W'(b);
    endfunction

endpackage

// File: rtl/mac_rr_arb2.sv
// Two-way round-robin grant: a lone requester wins, a tie goes to the pointed channel.
module mac_rr_arb2
    import mac_ctrl_pkg::*;
(
    input  logic [N_CHAN-1:0] req,
    input  logic              ptr,
    output logic [N_CHAN-1:0] gnt_c
);

    always_comb begin
        gnt_c = '0;
        if (req[0] && (!req[1] || !ptr)) begin
            gnt_c = 2'b01;
        end else if (req[1]) begin
            gnt_c = 2'b10;
        end
    end

endmodule

// File: rtl/mac_dot_arbiter.sv
// Two-channel dot-product accumulator: grants one channel per job, sums a*b per beat,
// and presents the wrapped sum, owning channel and sticky carry flag as one result.
module mac_dot_arbiter
    import mac_ctrl_pkg::*;
#(
    parameter int unsigned ACC_W = ACC_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_CHAN-1:0] req_valid,
    output logic [N_CHAN-1:0] req_ready,
    input  logic [OPND_W-1:0] req_a0,
    input  logic [OPND_W-1:0] req_b0,
    input  logic [OPND_W-1:0] req_a1,
    input  logic [OPND_W-1:0] req_b1,
    input  logic [N_CHAN-1:0] req_last,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [ACC_W-1:0]  res_data,
    output logic              res_chan,
    output logic              res_ovf
);

    logic [1:0]        state_q, state_d;
    logic              owner_q, owner_d;
    logic              ptr_q, ptr_d;
    logic              ovf_q, ovf_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [N_CHAN-1:0] ready_q, ready_d;
    logic              valid_q, valid_d;

    logic [N_CHAN-1:0] gnt_c;
    logic [OPND_W-1:0] a_sel_c, b_sel_c;
    logic [PROD_W-1:0] prod_c;
    logic [ACC_W:0]    sum_c;
    logic              beat_c;

    mac_rr_arb2 u_arb (
        .req   (req_valid),
        .ptr   (ptr_q),
        .gnt_c (gnt_c)
    );

    // Operand mux follows the current owner; ready_q is only non-zero in BUSY
    assign a_sel_c = owner_q ? req_a1 : req_a0;
    assign b_sel_c = owner_q ? req_b1 : req_b0;
    assign prod_c  = mul4(a_sel_c, b_sel_c);
    assign sum_c   = {1'b0, acc_q} + (ACC_W + 1)'(prod_c);
    assign beat_c  = |(req_valid & ready_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        ready_d = '0;
        case (state_q)
            ST_IDLE: begin
                if (|req_valid) begin
                    state_d = ST_BUSY;
                    owner_d = gnt_c[1];
                    acc_d   = '0;
                    ovf_d   = 1'b0;
                end
            end
            ST_BUSY: begin
                if (beat_c) begin
                    acc_d = sum_c[ACC_W-1:0];
                    ovf_d = ovf_q | sum_c[ACC_W];
                    if (req_last[owner_q]) begin
                        state_d = ST_RESULT;
                    end
                end
            end
            ST_RESULT: begin
                if (valid_q && res_ready) begin
                    state_d = ST_IDLE;
                    ptr_d   = ~owner_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (state_d == ST_BUSY) begin
            ready_d[owner_d] = 1'b1;
        end
        valid_d = (state_d == ST_RESULT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_q <= 1'b0;
            ptr_q   <= 1'b0;
            ovf_q   <= 1'b0;
            acc_q   <= '0;
            ready_q <= '0;
            valid_q <= 1'b0;
        end else begin
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            ovf_q   <= ovf_d;
            acc_q   <= acc_d;
            ready_q <= ready_d;
            valid_q <= valid_d;
        end
    end

    assign req_ready = ready_q;
    assign res_valid = valid_q;
    assign res_data  = acc_q;
    assign res_chan  = owner_q;
    assign res_ovf   = ovf_q;

endmodule

// File: tb/tb_mac_dot_arbiter.sv
// Self-checking bench for mac_dot_arbiter: directed table, contention rounds,
// mid-job reset and random jobs scored against an arithmetic sum model.
module tb_mac_dot_arbiter;

    localparam int unsigned ACC_W = 12;
    localparam int          MODV  = 1 << ACC_W;

    logic             clk = 1'b0;
    logic             rst;
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [3:0]       req_a0, req_b0, req_a1, req_b1;
    logic [1:0]       req_last;
    logic             res_valid;
    logic             res_ready;
    logic [ACC_W-1:0] res_data;
    logic             res_chan;
    logic             res_ovf;

    int total = 0;
    int bad   = 0;
    bit m_ptr = 1'b0;
    logic [3:0] beat_a [64];
    logic [3:0] beat_b [64];

    typedef struct {
        bit             ch;
        int             n;
        logic [2:0][3:0] a;
        logic [2:0][3:0] b;
        int             rr;
        bit             gaps;
        int             exp_data;
        bit             exp_ovf;
    } vec_t;

    vec_t tbl [7];

    mac_dot_arbiter #(.ACC_W(ACC_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a0    (req_a0),
        .req_b0    (req_b0),
        .req_a1    (req_a1),
        .req_b1    (req_b1),
        .req_last  (req_last),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_chan  (res_chan),
        .res_ovf   (res_ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic set_beat(input bit ch, input bit v, input logic [3:0] a,
                            input logic [3:0] b, input bit last);
        logic [3:0] a_use, b_use;
        a_use = v ? a : 4'($urandom);
        b_use = v ? b : 4'($urandom);
        req_valid[ch] = v;
        req_last[ch]  = last;
        if (ch) begin
            req_a1 = a_use;
            req_b1 = b_use;
        end else begin
            req_a0 = a_use;
            req_b0 = b_use;
        end
    endtask

    // Drives one job from beat_a/beat_b on channel ch, then checks and takes the result
    task automatic run_job(input bit ch, input int n, input int rr_wait, input bit gaps,
                           input int exp_data, input bit exp_ovf, input int exp_lat,
                           input string name);
        int i, cyc, lat;
        bit v, other_bad, hold_bad;
        logic [ACC_W-1:0] hd;
        logic hc, ho;
        i = 0; cyc = 0; lat = -1; other_bad = 0; hold_bad = 0;
        while (i < n && cyc < 4 * n + 40) begin
            v = (lat < 0) || !gaps || ($urandom_range(0, 3) != 0);
            set_beat(ch, v, beat_a[i], beat_b[i], i == n - 1);
            @(negedge clk);
            if (req_ready[!ch] !== 1'b0) other_bad = 1;
            if (req_ready[ch] === 1'b1) begin
                if (lat < 0) lat = cyc;
                if (v) i++;
            end
            cyc++;
            @(posedge clk); #1;
        end
        req_valid[ch] = 1'b0;
        req_last[ch]  = 1'b0;
        check({name, "_beats"}, i, n);
        if (exp_lat >= 0) check({name, "_grant_lat"}, lat, exp_lat);
        check({name, "_other_rdy"}, other_bad, 0);
        @(negedge clk);
        check({name, "_res_valid"}, res_valid, 1);
        check({name, "_rdy_in_result"}, req_ready, 0);
        hd = res_data; hc = res_chan; ho = res_ovf;
        for (int k = 0; k < rr_wait; k++) begin
            @(posedge clk); #1;
            @(negedge clk);
            if (res_valid !== 1'b1 || res_data !== hd || res_chan !== hc ||
                res_ovf !== ho || req_ready !== 2'b00) hold_bad = 1;
        end
        if (rr_wait > 0) check({name, "_hold"}, hold_bad, 0);
        check({name, "_data"}, res_data, exp_data);
        check({name, "_chan"}, res_chan, ch);
        check({name, "_ovf"}, res_ovf, exp_ovf);
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        m_ptr = !ch;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cnt, cyc, n, sum;
        bit ch, w, leak;
        logic [3:0] la, lb, wa, wb;

        tbl[0] = '{1'b0, 3,  {4'd15, 4'd2, 4'd3},  {4'd15, 4'd7, 4'd5},  0, 1'b0, 254,  1'b0};
        tbl[1] = '{1'b1, 19, {4'd15, 4'd15, 4'd15}, {4'd15, 4'd15, 4'd15}, 2, 1'b1, 179,  1'b1};
        tbl[2] = '{1'b0, 2,  {4'd0, 4'd7, 4'd8},    {4'd0, 4'd7, 4'd9},    1, 1'b0, 121,  1'b0};
        tbl[3] = '{1'b1, 1,  {4'd6, 4'd6, 4'd6},    {4'd6, 4'd6, 4'd6},    0, 1'b0, 36,   1'b0};
        tbl[4] = '{1'b0, 18, {4'd15, 4'd15, 4'd15}, {4'd15, 4'd15, 4'd15}, 0, 1'b1, 4050, 1'b0};
        tbl[5] = '{1'b1, 1,  {4'd0, 4'd0, 4'd0},    {4'd9, 4'd9, 4'd9},    0, 1'b0, 0,    1'b0};
        tbl[6] = '{1'b0, 20, {4'd0, 4'd1, 4'd15},   {4'd7, 4'd1, 4'd15},   3, 1'b1, 1582, 1'b0};

        // Reset with both channels requesting
        rst = 1'b1; req_valid = 2'b11; req_last = 2'b00; res_ready = 1'b0;
        req_a0 = 4'd0; req_b0 = 4'd0; req_a1 = 4'd0; req_b1 = 4'd0;
        repeat (3) @(negedge clk);
        check("rst_req_ready", req_ready, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_res_data", res_data, 0);
        check("rst_res_chan", res_chan, 0);
        check("rst_res_ovf", res_ovf, 0);
        req_valid = 2'b00;
        rst = 1'b0;
        @(posedge clk); #1;

        // Contention right after reset: ch0 first (held result), ch1 one idle cycle later
        set_beat(1'b1, 1'b1, 4'd6, 4'd6, 1'b1);
        beat_a[0] = 4'd4; beat_b[0] = 4'd4;
        run_job(1'b0, 1, 5, 1'b0, 16, 1'b0, 1, "cont_ch0");
        beat_a[0] = 4'd6; beat_b[0] = 4'd6;
        run_job(1'b1, 1, 0, 1'b0, 36, 1'b0, 1, "cont_ch1");

        // Directed table
        for (int t = 0; t < 7; t++) begin
            for (int k = 0; k < tbl[t].n; k++) begin
                beat_a[k] = tbl[t].a[k % 3];
                beat_b[k] = tbl[t].b[k % 3];
            end
            run_job(tbl[t].ch, tbl[t].n, tbl[t].rr, tbl[t].gaps,
                    tbl[t].exp_data, tbl[t].exp_ovf, 1, $sformatf("tbl%0d", t));
        end

        // Wrap boundaries: 4095 stays clean, exactly 4096 wraps to 0 with overflow
        for (int k = 0; k < 18; k++) begin beat_a[k] = 4'd15; beat_b[k] = 4'd15; end
        beat_a[18] = 4'd9; beat_b[18] = 4'd5;
        run_job(1'b1, 19, 0, 1'b0, 4095, 1'b0, 1, "edge_4095");
        for (int k = 0; k < 17; k++) begin beat_a[k] = 4'd15; beat_b[k] = 4'd15; end
        beat_a[17] = 4'd14; beat_b[17] = 4'd14;
        beat_a[18] = 4'd15; beat_b[18] = 4'd5;
        run_job(1'b0, 19, 1, 1'b0, 0, 1'b1, 1, "edge_4096");

        // Pointer follows the last owner: solo job on s, then contention must favour !s
        for (int r = 0; r < 2; r++) begin
            ch = 1'(r);
            beat_a[0] = 4'd5; beat_b[0] = 4'd3;
            run_job(ch, 1, 0, 1'b0, 15, 1'b0, 1, "solo");
            w = m_ptr;
            la = 4'($urandom); lb = 4'($urandom);
            wa = 4'($urandom); wb = 4'($urandom);
            set_beat(!w, 1'b1, la, lb, 1'b1);
            beat_a[0] = wa; beat_b[0] = wb;
            run_job(w, 1, 2, 1'b0, int'(wa) * int'(wb), 1'b0, 1, "rr_win");
            beat_a[0] = la; beat_b[0] = lb;
            run_job(!w, 1, 0, 1'b0, int'(la) * int'(lb), 1'b0, 1, "rr_lose");
        end

        // Random jobs against the plain-sum model
        for (int j = 0; j < 40; j++) begin
            ch  = 1'($urandom_range(0, 1));
            n   = $urandom_range(1, 24);
            sum = 0;
            for (int k = 0; k < n; k++) begin
                beat_a[k] = 4'($urandom);
                beat_b[k] = 4'($urandom);
                sum += int'(beat_a[k]) * int'(beat_b[k]);
            end
            run_job(ch, n, $urandom_range(0, 3), 1'b1, sum % MODV, sum >= MODV, 1, "rnd");
        end

        // Reset in the middle of a ch0 job discards it
        set_beat(1'b0, 1'b1, 4'd9, 4'd9, 1'b0);
        cnt = 0; cyc = 0;
        while (cnt < 2 && cyc < 20) begin
            @(negedge clk);
            if (req_ready[0] === 1'b1) cnt++;
            cyc++;
            @(posedge clk); #1;
        end
        check("midrst_beats", cnt, 2);
        #2 rst = 1'b1;
        @(negedge clk);
        check("midrst_req_ready", req_ready, 0);
        check("midrst_res_valid", res_valid, 0);
        check("midrst_res_data", res_data, 0);
        check("midrst_res_ovf", res_ovf, 0);
        req_valid = 2'b00;
        req_last  = 2'b00;
        @(negedge clk);
        rst = 1'b0;
        leak = 0;
        repeat (4) begin
            @(negedge clk);
            if (res_valid !== 1'b0) leak = 1;
        end
        check("midrst_no_partial", leak, 0);
        @(posedge clk); #1;
        m_ptr = 1'b0;
        beat_a[0] = 4'd2; beat_b[0] = 4'd3;
        run_job(1'b0, 1, 0, 1'b0, 6, 1'b0, 1, "after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mac_dot_arbiter.md
MAC_DOT_ARBITER -- requirements
Module: mac_dot_arbiter

Interface
REQ-001 Parameter ACC_W, default 12, SHALL set the accumulator and result width in bits (legal range 9..16).
REQ-002 clk  input  1  SHALL be the clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  SHALL be the reset: asynchronous, active-high.
REQ-004 req_valid  input  2  SHALL flag, per channel (bit i = channel i), that an operand beat is offered.
REQ-005 req_ready  output  2  SHALL flag, per channel, that the offered beat is accepted this cycle.
REQ-006 req_a0, req_b0  input  4 each  SHALL carry the channel-0 operands (unsigned).
REQ-007 req_a1, req_b1  input  4 each  SHALL carry the channel-1 operands (unsigned).
REQ-008 req_last  input  2  SHALL mark, per channel, the final beat of a dot-product job.
REQ-009 res_valid  output  1  SHALL flag that a job result is presented.
REQ-010 res_ready  input  1  SHALL flag that the consumer takes the result this cycle.
REQ-011 res_data  output  ACC_W  SHALL carry the job sum modulo 2^ACC_W.
REQ-012 res_chan  output  1  SHALL carry the channel that owned the job.
REQ-013 res_ovf  output  1  SHALL flag that at least one accumulation carried out of ACC_W bits during the job.

Function
REQ-014 A beat SHALL transfer on channel i only in a cycle where req_valid[i] and req_ready[i] are both 1.
REQ-015 The FSM SHALL have exactly three states: IDLE, BUSY, RESULT.
REQ-016 IDLE: req_ready=00 and res_valid=0; if any req_valid bit is 1, the FSM SHALL grant one channel, clear the accumulator and overflow flag, and enter BUSY next cycle.
REQ-017 Grant SHALL be round-robin: a lone requester wins; if both request, the channel indicated by the priority pointer wins.
REQ-018 BUSY: req_ready SHALL be 1 only for the owner and 0 for the other channel; one beat per cycle SHALL be accepted with no bubbles.
REQ-019 Each accepted beat SHALL add the 8-bit unsigned product a*b, zero-extended, to the accumulator; the sum SHALL wrap modulo 2^ACC_W and any carry-out SHALL set the sticky overflow flag.
REQ-020 A beat with req_last=1 accepted in BUSY SHALL move the FSM to RESULT; res_valid SHALL rise the next cycle, with res_data including that beat's product.
REQ-021 Owner deasserting req_valid in BUSY SHALL stall the job without changing the accumulator; there SHALL be no timeout.
REQ-022 RESULT: req_ready=00; res_data, res_chan and res_ovf SHALL remain stable until res_valid and res_ready are both 1.
REQ-023 On the result handshake the FSM SHALL return to IDLE and the priority pointer SHALL point to the channel that did not own the job.
REQ-024 A single-beat job (req_last=1 on the first beat) SHALL produce a result equal to that beat's product.
REQ-025 A new grant SHALL occur no earlier than the cycle after the result handshake (minimum 1 idle cycle between jobs).

Reset
REQ-026 While rst=1: state=IDLE, accumulator=0, overflow flag=0, priority pointer=channel 0, req_ready=00, res_valid=0, res_data=0, res_chan=0, res_ovf=0.
REQ-027 rst asserted mid-job SHALL discard the job; no partial result SHALL ever be presented.

Structure
REQ-028 A shared package mac_ctrl_pkg SHALL hold the FSM state encoding, the channel count (2) and the ACC_W default.
REQ-029 The round-robin grant logic SHALL be a sub-module named mac_rr_arb2 (inputs: request vector, priority pointer; output: one-hot grant).
REQ-030 The 4x4 product SHALL be computed combinationally inside the block; no multiplier pipeline stage SHALL be added.

Verification
REQ-031 Reset: hold rst=1 with req_valid=11 -> req_ready=00, res_valid=0, res_data=0, res_chan=0, res_ovf=0.
REQ-032 Channel-0 job (3,5), (2,7), (15,15) with last on the third beat -> res_data=254, res_chan=0, res_ovf=0, res_valid 1 cycle after the last beat.
REQ-033 Both channels valid after reset, single-beat jobs ch0 (4,4) and ch1 (6,6) -> ch0 served first with result 16; req_ready[1]=0 throughout; ch1 served next with result 36.
REQ-034 ACC_W=12, channel 1 sends 19 beats of (15,15) -> res_data=179, res_ovf=1, res_chan=1.
REQ-035 res_ready=0 for 5 cycles in RESULT -> outputs stable, req_ready=00; after the handshake the other pending channel is granted.
REQ-036 rst pulse after 2 beats of a ch0 job, then a new job (2,3) last -> res_data=6, res_ovf=0.
